wb_bram_slave: RTL and testbench
================================

# wb_bram_slave

Pipelined Wishbone responder that backs one memory bank behind the memory system's five-way bank decoder. It sits on the slave side of one bank port, for example bank 1 (RAM, bank-relative byte addresses). It accepts one strobe per cycle and writes with byte-enables into a synchronous block RAM. Every accepted request gets exactly one in-order ack or err a fixed number of cycles later. After reset it can optionally zero the whole array, stalling the bus while it does so.

## Interface
- AW, 32, address width (bank-relative byte address)
- MW, 64, data word width in bits
- BW, MW/8, byte-enable width
- DEPTH_WORDS, 4096, number of MW-bit words stored; power of two
- LATENCY, 2, accept-to-response delay in cycles; legal range 1..4
- INIT_ZERO, 1, 1 = clear all words after reset; 0 = contents left as-is
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset; asynchronous assert, active-low (0 = reset)
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  AW  bank-relative byte address
- i_wb_data  in  MW  write data
- i_wb_be  in  BW  byte enables; bit k covers data[8k+7:8k]
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_ack  out  1  successful response, one cycle per request
- o_wb_err  out  1  error response, one cycle per request
- o_wb_data  out  MW  read data; qualified by o_wb_ack on reads

## Operation
- Acceptance: a request is accepted on a rising edge where i_wb_stb=1 and o_wb_stall=0. A strobe seen while stalled is ignored and gets no response.
- Address decode: word index = i_wb_addr[AW-1:log2(BW)].
  - Misaligned requests (i_wb_addr[log2(BW)-1:0] != 0) get err.
  - Out-of-range requests (index >= DEPTH_WORDS) get err.
  - An err request never touches the RAM.
- Write: on the accept edge, the RAM updates only the bytes whose be bit is 1. be=0 is legal: no change, still acked. The response is ack with o_wb_data=0.
- Read: returns the full word; be is ignored.
- Read after write: a read accepted the cycle after a write to the same word returns the newly written bytes (write-first).
- State machine:
  - INIT: o_wb_stall=1. A counter init_idx steps 0..DEPTH_WORDS-1, writing zero to each word. When INIT_ZERO=0, INIT lasts one cycle with no writes. INIT -> READY after the last word.
  - READY: o_wb_stall=0, one request per cycle. READY is left only by reset.
- Response pipeline:
  - LATENCY-stage shift register of {valid, err, we}, plus a data stage after the registered RAM output.
  - Responses are strictly in acceptance order. o_wb_ack and o_wb_err are never both 1.
- o_wb_data is 0 in every cycle that is not a read ack.

## Timing
- Reset (i_reset=0), immediately and asynchronously:
  - o_wb_stall=1, o_wb_ack=0, o_wb_err=0, o_wb_data=0.
  - Pipeline valid bits cleared; state=INIT; init_idx=0.
- Reset mid-operation: in-flight requests are dropped and never acked. Writes already committed to RAM persist unless INIT_ZERO clears them.
- After reset release, o_wb_stall stays 1 for exactly DEPTH_WORDS rising edges (INIT_ZERO=1) or 1 edge (INIT_ZERO=0), then falls.
- Latency: a request accepted at edge N produces ack/err high during the cycle after edge N+LATENCY-1. That is, LATENCY=1 means the response appears in the cycle immediately following acceptance.
- Throughput: back-to-back strobes in READY give back-to-back responses, one per cycle, with no bubbles.
- Read and write interleave freely. Err responses keep their slot in the order.

## Test plan
- Reset/init: INIT_ZERO=1, DEPTH_WORDS=16.
  - Release reset -> stall=1 for 16 edges, then 0.
  - Read address 0x78 -> ack with data 0x0000000000000000 at LATENCY=2.
- Byte-enable write:
  - Write 0x1122334455667788 to 0x08 with be=0xFF, then 0xAAAAAAAAAAAAAAAA with be=0x0F.
  - Read 0x08 -> 0x11223344AAAAAAAA.
- Pipelined stream, LATENCY=2:
  - 8 consecutive strobes alternating write/read to words 0..3 -> 8 consecutive acks, in order, each 2 cycles after its accept.
  - Each read returns the value of the preceding write.
- Errors:
  - Read 0x0C (misaligned) -> err, data 0.
  - Read 0x80 with DEPTH_WORDS=16 -> err.
  - Write to 0x80 -> err, RAM unchanged.
  - A neighbouring valid request still gets ack in order.
- Reset mid-stream:
  - Assert reset 1 cycle after accepting 3 reads -> ack=0 immediately; no stale acks after release.
  - Stall re-asserted through INIT.
- Stall respect: strobe asserted during INIT -> no response ever generated for it.

Source files
------------

// File: rtl/wb_bram_slave.sv
// Pipelined Wishbone block-RAM responder for one bank port: byte-enable writes,
// in-order ack/err after LATENCY cycles, optional zero-fill of the array after reset.
module wb_bram_slave #(
  parameter int AW          = 32,
  parameter int MW          = 64,
  parameter int BW          = MW / 8,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2,
  parameter int INIT_ZERO   = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [MW-1:0] i_wb_data,
  input  logic [BW-1:0] i_wb_be,
  output logic          o_wb_stall,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  output logic [MW-1:0] o_wb_data
);

  localparam int BSH = $clog2(BW);
  localparam int IW  = $clog2(DEPTH_WORDS);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_idx_q, init_idx_d;
  logic          init_we;

  logic          accept;
  logic          req_misalign;
  logic          req_oor;
  logic          req_err;
  logic [IW-1:0] word_idx;

  logic          ram_we;
  logic          ram_re;
  logic [IW-1:0] ram_addr;
  logic [MW-1:0] ram_wdata;
  logic [BW-1:0] ram_be;
  logic [MW-1:0] mem_q [DEPTH_WORDS];

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [LATENCY-1:0] we_q;
  logic [MW-1:0]      dat_q [LATENCY];

  // Request decode: the word index is taken from the bits above the byte offset,
  // anything set above the array's index bits is out of range.
  assign accept       = i_wb_stb && (state_q == S_READY);
  assign req_misalign = |i_wb_addr[BSH-1:0];
  assign req_oor      = |i_wb_addr[AW-1:BSH+IW];
  assign req_err      = req_misalign || req_oor;
  assign word_idx     = i_wb_addr[BSH+IW-1:BSH];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    init_we    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (INIT_ZERO != 0) begin
          init_we = 1'b1;
          if (init_idx_q == IW'(DEPTH_WORDS - 1)) begin
            state_d = S_READY;
          end else begin
            init_idx_d = init_idx_q + 1'b1;
          end
        end else begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // RAM port is shared between the zero-fill sweep and bus requests; the two
  // never overlap because the bus is stalled for the whole sweep.
  assign ram_we    = init_we || (accept && i_wb_we && !req_err);
  assign ram_re    = accept && !i_wb_we && !req_err;
  assign ram_addr  = init_we ? init_idx_q : word_idx;
  assign ram_wdata = init_we ? '0 : i_wb_data;
  assign ram_be    = init_we ? '1 : i_wb_be;

  always_ff @(posedge i_clk) begin
    if (ram_we) begin
      for (int k = 0; k < BW; k++) begin
        if (ram_be[k]) begin
          mem_q[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
        end
      end
    end
  end

  // Stage 0: registered RAM output, then the data shift line to the response slot
  always_ff @(posedge i_clk) begin
    if (ram_re) begin
      dat_q[0] <= mem_q[word_idx];
    end
    for (int k = 1; k < LATENCY; k++) begin
      dat_q[k] <= dat_q[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vld_q <= '0;
      err_q <= '0;
      we_q  <= '0;
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= req_err;
      we_q[0]  <= i_wb_we;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        err_q[k] <= err_q[k-1];
        we_q[k]  <= we_q[k-1];
      end
    end
  end

  // Response slot: outputs derive only from reset-cleared control bits, so
  // everything drops to zero the moment reset asserts.
  assign o_wb_stall = (state_q != S_READY);
  assign o_wb_ack   = vld_q[LATENCY-1] && !err_q[LATENCY-1];
  assign o_wb_err   = vld_q[LATENCY-1] && err_q[LATENCY-1];
  assign o_wb_data  = (o_wb_ack && !we_q[LATENCY-1]) ? dat_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Directed bench for wb_bram_slave: DEPTH_WORDS=16, LATENCY=2, INIT_ZERO=1.
module tb_wb_bram_slave;

  logic        clk;
  logic        rst_n;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        stall;
  logic        ack;
  logic        err;
  logic [63:0] rdata;

  int vectors;
  int miscompares;

  logic        s_we   [16];
  logic [31:0] s_addr [16];
  logic [63:0] s_dat  [16];
  logic [7:0]  s_be   [16];
  logic        e_ack  [16];
  logic        e_err  [16];
  logic [63:0] e_dat  [16];

  wb_bram_slave #(
    .AW(32), .MW(64), .BW(8), .DEPTH_WORDS(16), .LATENCY(2), .INIT_ZERO(1)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_be(be),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic ld(input int i, input logic w, input logic [31:0] a, input logic [63:0] d,
                    input logic [7:0] b, input logic ea, input logic ee, input logic [63:0] ed);
    s_we[i] = w; s_addr[i] = a; s_dat[i] = d; s_be[i] = b;
    e_ack[i] = ea; e_err[i] = ee; e_dat[i] = ed;
  endtask

  // Drives n back-to-back requests; after edge i the response of request i-1 must be visible.
  task automatic run_stream(input string name, input int n);
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        stb = 1'b1; we = s_we[i]; addr = s_addr[i]; wdata = s_dat[i]; be = s_be[i];
      end else begin
        stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      end
      @(posedge clk); #1;
      if (i >= 1 && i <= n) begin
        chk($sformatf("%s[%0d].ack", name, i - 1), 64'(ack), 64'(e_ack[i-1]));
        chk($sformatf("%s[%0d].err", name, i - 1), 64'(err), 64'(e_err[i-1]));
        chk($sformatf("%s[%0d].data", name, i - 1), rdata, e_dat[i-1]);
      end else begin
        chk($sformatf("%s.idle%0d.resp", name, i), 64'({ack, err}), 64'd0);
        chk($sformatf("%s.idle%0d.data", name, i), rdata, 64'd0);
      end
    end
  endtask

  task automatic wait_init(input string name);
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (stall === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      seen = seen | ack | err;
    end
    stb = 1'b0;
    chk({name, ".stall_edges"}, 64'(n), 64'd16);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | ack | err;
    end
    chk({name, ".no_resp"}, 64'(seen), 64'd0);
    chk({name, ".stall_low"}, 64'(stall), 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset.stall", 64'(stall), 64'd1);
    chk("reset.ack", 64'(ack), 64'd0);
    chk("reset.err", 64'(err), 64'd0);
    chk("reset.data", rdata, 64'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // strobe held through INIT must never be answered
    stb = 1'b1; we = 1'b0; addr = 32'h0;
    wait_init("init1");

    ld(0, 1'b0, 32'h78, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    run_stream("rd_cleared", 1);

    ld(0, 1'b1, 32'h08, 64'h1122334455667788, 8'hFF, 1'b1, 1'b0, 64'h0);
    ld(1, 1'b1, 32'h08, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 1'b1, 1'b0, 64'h0);
    ld(2, 1'b0, 32'h08, 64'h0, 8'h00, 1'b1, 1'b0, 64'h11223344AAAAAAAA);
    run_stream("byte_en", 3);

    ld(0, 1'b0, 32'h08, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h11223344AAAAAAAA);
    ld(1, 1'b0, 32'h0C, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0);
    ld(2, 1'b0, 32'h80, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h0);
    ld(3, 1'b1, 32'h80, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0, 1'b1, 64'h0);
    ld(4, 1'b0, 32'h00, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    ld(5, 1'b0, 32'h08, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h11223344AAAAAAAA);
    run_stream("errors", 6);

    ld(0, 1'b1, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1'b1, 1'b0, 64'h0);
    ld(1, 1'b0, 32'h10, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    run_stream("be_zero", 2);

    for (int k = 0; k < 4; k++) begin
      ld(2*k,   1'b1, 32'(8*k), 64'h0123456789ABCD00 | 64'(k), 8'hFF, 1'b1, 1'b0, 64'h0);
      ld(2*k+1, 1'b0, 32'(8*k), 64'h0, 8'h00, 1'b1, 1'b0, 64'h0123456789ABCD00 | 64'(k));
    end
    run_stream("pipe", 8);

    // three reads, reset asserted while the second response is on the bus
    stb = 1'b1; we = 1'b0; be = 8'hFF;
    addr = 32'h00; @(posedge clk); #1;
    addr = 32'h08; @(posedge clk); #1;
    chk("midrst.ack0", 64'(ack), 64'd1);
    chk("midrst.data0", rdata, 64'h0123456789ABCD00);
    addr = 32'h10; @(posedge clk); #1;
    stb = 1'b0;
    chk("midrst.ack1", 64'(ack), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.ack_drop", 64'(ack), 64'd0);
    chk("midrst.data_drop", rdata, 64'd0);
    chk("midrst.stall", 64'(stall), 64'd1);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_init("init2");

    ld(0, 1'b0, 32'h00, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    ld(1, 1'b0, 32'h08, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    run_stream("recleared", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
